multi_channel_debouncer: RTL and testbench

Parametrised successor to the single-input slow-clock/two-flop debouncer. It debounces CHANNELS mechanical inputs and generates one shared sample tick internally from i_clk, so no derived clock is needed. Each channel gets a synchroniser and a consecutive-sample stability counter. Each channel outputs a clean level plus one-cycle rise and fall pulses. Sits between board switches/buttons and user logic, fully in the i_clk domain.

---
 rtl/debounce_pkg.sv | 22 ++
 rtl/debounce_channel.sv | 81 ++++++++
 rtl/multi_channel_debouncer.sv | 63 ++++++
 tb/tb_multi_channel_debouncer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared defaults and elaboration helpers for the multi-channel debouncer.
// Imported by the top-level prescaler and by the per-channel debounce logic.
package debounce_pkg;

  localparam int DEF_CLK_DIV      = 50000;
  localparam int DEF_STABLE_TICKS = 4;
  localparam int DEF_SYNC_STAGES  = 2;

  // Ceiling log2, never below one bit so degenerate parameters still elaborate.
  function automatic int clog2(input int value);
    int width;
    width = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      width = width + 1;
    end
    if (width < 1) begin
      width = 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: synchroniser, consecutive-disagreement counter,
// accepted level and single-cycle rise/fall pulses, advanced only on i_tick.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_tick,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int                     CNT_W     = clog2(STABLE_TICKS + 1);
  localparam logic [CNT_W-1:0]       CNT_LAST  = CNT_W'(STABLE_TICKS - 1);
  localparam logic [SYNC_STAGES-1:0] SYNC_IDLE = {SYNC_STAGES{ACTIVE_LOW}};

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic                   level_q;
  logic                   level_d;
  logic                   rise_q;
  logic                   rise_d;
  logic                   fall_q;
  logic                   fall_d;
  logic                   sample;

  // Polarity is folded in after the last stage so outputs are always active-high.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], i_btn};
    sample = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;
  end

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (i_tick) begin
      if (sample == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        // Enough consecutive disagreeing samples: accept and flag the edge.
        cnt_d   = '0;
        level_d = sample;
        rise_d  = sample;
        fall_d  = ~sample;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q  <= SYNC_IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign o_level = level_q;
  assign o_rise  = rise_q;
  assign o_fall  = fall_q;

endmodule

// File: rtl/multi_channel_debouncer.sv
// CHANNELS independent switch debouncers sharing one i_clk-derived sample tick.
// The prescaler lives here; each channel is a debounce_channel enabled by o_tick.
module multi_channel_debouncer
  import debounce_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int CLK_DIV      = DEF_CLK_DIV,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int ACTIVE_LOW   = 0
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [CHANNELS-1:0] i_btn,
  output logic [CHANNELS-1:0] o_level,
  output logic [CHANNELS-1:0] o_rise,
  output logic [CHANNELS-1:0] o_fall,
  output logic                o_tick
);

  localparam int               DIV_W    = clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic             tick_q;
  logic             tick_d;

  // The strobe is registered, so it lands in the cycle after the terminal count.
  always_comb begin
    tick_d = (div_q == DIV_LAST);
    div_d  = tick_d ? '0 : div_q + DIV_W'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
    end
  end

  assign o_tick = tick_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    debounce_channel #(
      .STABLE_TICKS (STABLE_TICKS),
      .SYNC_STAGES  (SYNC_STAGES),
      .ACTIVE_LOW   (ACTIVE_LOW != 0)
    ) u_ch (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_tick  (tick_q),
      .i_btn   (i_btn[g]),
      .o_level (o_level[g]),
      .o_rise  (o_rise[g]),
      .o_fall  (o_fall[g])
    );
  end

endmodule

// File: tb/tb_multi_channel_debouncer.sv
// Scoreboard bench: a window-based reference model predicts debounced edges,
// a negedge monitor compares level, tick and pulses against its predictions.
module tb_multi_channel_debouncer;

  localparam int CH           = 2;
  localparam int CLK_DIV      = 4;
  localparam int STABLE_TICKS = 3;
  localparam int SYNC_STAGES  = 2;

  logic          clk;
  logic          rst_n;
  logic [CH-1:0] i_btn;
  logic [CH-1:0] o_level;
  logic [CH-1:0] o_rise;
  logic [CH-1:0] o_fall;
  logic          o_tick;

  typedef struct {
    int            cyc;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
  } ev_t;

  ev_t           exp_q[$];
  logic [CH-1:0] hist[$];
  logic [CH-1:0] ticks[$];
  logic [CH-1:0] mdl_level;
  int            n;
  int            checks;
  int            errors;

  int            m;
  logic [CH-1:0] r_v;
  logic [CH-1:0] f_v;
  bit            all_diff;

  multi_channel_debouncer #(
    .CHANNELS     (CH),
    .CLK_DIV      (CLK_DIV),
    .STABLE_TICKS (STABLE_TICKS),
    .SYNC_STAGES  (SYNC_STAGES),
    .ACTIVE_LOW   (0)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_btn   (i_btn),
    .o_level (o_level),
    .o_rise  (o_rise),
    .o_fall  (o_fall),
    .o_tick  (o_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, n, act, exp);
    end
  endtask

  // Reference model: n counts rising edges since reset release; hist[k] is the
  // input held during cycle k. A tick in cycle k sees the input from k-SYNC_STAGES.
  // A level is accepted when the last STABLE_TICKS tick samples all differ from it.
  initial begin
    n         = 0;
    mdl_level = '0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        n         = 0;
        mdl_level = '0;
        hist.delete();
        ticks.delete();
      end else begin
        n = n + 1;
        hist.push_back(i_btn);
        m = n - 1;
        if (m > 0 && (m % CLK_DIV) == 0) begin
          ticks.push_back(hist[m - SYNC_STAGES]);
          r_v = '0;
          f_v = '0;
          if (ticks.size() >= STABLE_TICKS) begin
            for (int c = 0; c < CH; c++) begin
              all_diff = 1'b1;
              for (int k = 1; k <= STABLE_TICKS; k++) begin
                if (ticks[ticks.size() - k][c] == mdl_level[c]) all_diff = 1'b0;
              end
              if (all_diff) begin
                if (mdl_level[c]) f_v[c] = 1'b1;
                else              r_v[c] = 1'b1;
                mdl_level[c] = ~mdl_level[c];
              end
            end
          end
          if ((r_v | f_v) != '0) exp_q.push_back('{n, r_v, f_v});
        end
      end
    end
  end

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  initial begin
    checks = 0;
    errors = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("reset_outputs", int'({o_level, o_rise, o_fall, o_tick}), 0);
      end else begin
        check("tick", int'(o_tick), int'(n > 0 && (n % CLK_DIV) == 0));
        check("level", int'(o_level), int'(mdl_level));
        while (exp_q.size() > 0 && exp_q[0].cyc < n) begin
          check("missed_pulse", 0, exp_q[0].cyc);
          void'(exp_q.pop_front());
        end
        if ((o_rise | o_fall) != '0) begin
          if (exp_q.size() == 0 || exp_q[0].cyc != n) begin
            check("unexpected_pulse", int'({o_rise, o_fall}), 0);
          end else begin
            check("rise", int'(o_rise), int'(exp_q[0].rise));
            check("fall", int'(o_fall), int'(exp_q[0].fall));
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic hold(input logic [CH-1:0] v, input int cycles);
    i_btn = v;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    #1 rst_n = 1'b0;
    repeat (cycles) @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    i_btn = 2'b11;
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    hold(2'b11, 40);
    hold(2'b00, 40);

    // Bounce on ch0 shorter than the acceptance window, then settle low.
    for (int k = 0; k < 10; k++) hold((k % 2) == 0 ? 2'b01 : 2'b00, 6);
    hold(2'b00, 40);

    hold(2'b01, 40);
    hold(2'b00, 40);
    hold(2'b11, 40);
    hold(2'b01, 40);
    hold(2'b00, 40);

    // Reset while ch0 is part-way through its acceptance window.
    hold(2'b01, 10);
    do_reset(4);
    hold(2'b01, 40);
    hold(2'b00, 40);

    for (int it = 0; it < 220; it++) begin
      if ($urandom_range(0, 39) == 0) do_reset(int'($urandom_range(1, 6)));
      hold(CH'($urandom_range(0, 3)), int'($urandom_range(1, 16)));
    end
    hold(2'b00, 40);

    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
